// File: rtl/axi4_lite_selftest_master_if.sv
// AXI4-Lite bus bundle between the self-test master and the register slave.
interface axi4_lite_selftest_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_selftest_master.sv
// AXI4-Lite self-test master: writes an incrementing pattern to consecutive
// word addresses, reads every word back, and reports done/error status.
// Optional handshake watchdog and TIMEOUT port: define AXI_SELFTEST_TIMEOUT_EN.
module axi4_lite_selftest_master #(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_NUM_TRANSACTIONS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_START_DATA       = 32'h0000_0001
`ifdef AXI_SELFTEST_TIMEOUT_EN
    ,
    parameter int unsigned                   C_TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               INIT_TXN,
    output logic                               TXN_DONE,
    output logic                               BUSY,
    output logic                               ERROR,
    output logic [8:0]                         ERR_COUNT,
`ifdef AXI_SELFTEST_TIMEOUT_EN
    output logic                               TIMEOUT,
`endif
    axi4_lite_selftest_master_if.master        M_AXI
);

    localparam int unsigned ADDR_W   = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W   = C_M_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W    = (C_NUM_TRANSACTIONS > 1) ? $clog2(C_NUM_TRANSACTIONS) : 1;
    localparam int unsigned LAST_IDX = C_NUM_TRANSACTIONS - 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic              init_q;
    logic              issued;
    logic              aw_done;
    logic              w_done;
    logic              aw_valid;
    logic              w_valid;
    logic              b_ready;
    logic              ar_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] ar_addr;

    logic start_c;
    logic last_c;
    logic aw_hs_c;
    logic w_hs_c;

    // Address of word idx.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return C_BASE_ADDR + (ADDR_W'(idx) << 2);
    endfunction

    // Pattern value of word idx, wrapping modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] word_data(input logic [IDX_W-1:0] idx);
        return C_START_DATA + DATA_W'(idx);
    endfunction

    // Saturating error counter increment.
    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    // Rising edge of the start request, qualified by the idle/done states.
    assign start_c = INIT_TXN && !init_q && ((state == IDLE) || (state == DONE));
    assign last_c  = (index == IDX_W'(LAST_IDX));
    assign aw_hs_c = aw_valid && M_AXI.awready;
    assign w_hs_c  = w_valid && M_AXI.wready;

    // Bus outputs come straight from registers; protection and strobes are fixed.
    assign M_AXI.awaddr  = aw_addr;
    assign M_AXI.awprot  = 3'b000;
    assign M_AXI.awvalid = aw_valid;
    assign M_AXI.wdata   = w_data;
    assign M_AXI.wstrb   = '1;
    assign M_AXI.wvalid  = w_valid;
    assign M_AXI.bready  = b_ready;
    assign M_AXI.araddr  = ar_addr;
    assign M_AXI.arprot  = 3'b000;
    assign M_AXI.arvalid = ar_valid;
    assign M_AXI.rready  = r_ready;

`ifdef AXI_SELFTEST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            any_hs_c;

    assign any_hs_c = aw_hs_c || w_hs_c
                   || (b_ready && M_AXI.bvalid)
                   || (ar_valid && M_AXI.arready)
                   || (r_ready && M_AXI.rvalid);
`endif

    // Sequencer: one transaction at a time, write phase then read-back phase.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            index     <= '0;
            init_q    <= 1'b0;
            issued    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            aw_addr   <= '0;
            w_data    <= '0;
            ar_addr   <= '0;
            TXN_DONE  <= 1'b0;
            BUSY      <= 1'b0;
            ERROR     <= 1'b0;
            ERR_COUNT <= '0;
`ifdef AXI_SELFTEST_TIMEOUT_EN
            TIMEOUT   <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            init_q <= INIT_TXN;

            case (state)
                IDLE, DONE: begin
                    if (start_c) begin
                        state     <= WR_ADDR_DATA;
                        index     <= '0;
                        issued    <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        TXN_DONE  <= 1'b0;
                        BUSY      <= 1'b1;
                        ERROR     <= 1'b0;
                        ERR_COUNT <= '0;
`ifdef AXI_SELFTEST_TIMEOUT_EN
                        TIMEOUT   <= 1'b0;
`endif
                    end
                end

                WR_ADDR_DATA: begin
                    if (!issued) begin
                        // First cycle of the write: raise both VALIDs together.
                        issued   <= 1'b1;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        aw_addr  <= word_addr(index);
                        w_data   <= word_data(index);
                    end else begin
                        if (aw_hs_c) begin
                            aw_valid <= 1'b0;
                            aw_done  <= 1'b1;
                        end
                        if (w_hs_c) begin
                            w_valid <= 1'b0;
                            w_done  <= 1'b1;
                        end
                        if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) begin
                            state   <= WR_RESP;
                            b_ready <= 1'b1;
                        end
                    end
                end

                WR_RESP: begin
                    if (M_AXI.bvalid) begin
                        b_ready <= 1'b0;
                        if (M_AXI.bresp != 2'b00) begin
                            ERROR     <= 1'b1;
                            ERR_COUNT <= sat_inc(ERR_COUNT);
                        end
                        if (last_c) begin
                            index    <= '0;
                            state    <= RD_ADDR;
                            ar_valid <= 1'b1;
                            ar_addr  <= word_addr('0);
                        end else begin
                            index   <= index + IDX_W'(1);
                            state   <= WR_ADDR_DATA;
                            issued  <= 1'b0;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end
                    end
                end

                RD_ADDR: begin
                    if (M_AXI.arready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (M_AXI.rvalid) begin
                        r_ready <= 1'b0;
                        // Data mismatch and bad response count once per read.
                        if ((M_AXI.rdata != word_data(index)) || (M_AXI.rresp != 2'b00)) begin
                            ERROR     <= 1'b1;
                            ERR_COUNT <= sat_inc(ERR_COUNT);
                        end
                        if (last_c) begin
                            state    <= DONE;
                            BUSY     <= 1'b0;
                            TXN_DONE <= 1'b1;
                        end else begin
                            index    <= index + IDX_W'(1);
                            state    <= RD_ADDR;
                            ar_valid <= 1'b1;
                            ar_addr  <= word_addr(index + IDX_W'(1));
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef AXI_SELFTEST_TIMEOUT_EN
            // Watchdog: abort the run if no handshake occurs for too long.
            if ((state == IDLE) || (state == DONE)) begin
                to_cnt <= '0;
            end else if (any_hs_c) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(C_TIMEOUT_CYCLES - 1)) begin
                to_cnt    <= '0;
                aw_valid  <= 1'b0;
                w_valid   <= 1'b0;
                b_ready   <= 1'b0;
                ar_valid  <= 1'b0;
                r_ready   <= 1'b0;
                ERROR     <= 1'b1;
                ERR_COUNT <= sat_inc(ERR_COUNT);
                TIMEOUT   <= 1'b1;
                BUSY      <= 1'b0;
                TXN_DONE  <= 1'b1;
                state     <= DONE;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
`endif
        end
    end

endmodule

// File: doc/axi4_lite_selftest_master.md
Name: axi4_lite_selftest_master

Overview:
- AXI4-Lite master stage that sits directly upstream of the 4-register AXI4-Lite slave peripheral.
- On a start request it writes an incrementing data pattern to consecutive register addresses. It then reads every address back and compares against the written data.
- Reports done and error status to the MicroBlaze-side control logic and to bring-up LEDs.
- Replaces the simulation-only VIP write/readback sequence with synthesizable hardware.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address bus width.
- C_M_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_NUM_TRANSACTIONS, 4, number of words written and read; range 1..256.
- C_BASE_ADDR, 32'h0000_0000, address of word 0; word i is at C_BASE_ADDR + 4*i.
- C_START_DATA, 32'h0000_0001, data of word 0; word i = C_START_DATA + i, modulo 2^32.
- C_TIMEOUT_CYCLES, 1024, handshake watchdog limit; used only with the optional feature.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- INIT_TXN  in  1  start request; the rising edge is detected internally.
- TXN_DONE  out  1  high once the read phase completes; held until the next accepted start.
- BUSY  out  1  high from an accepted start until completion.
- ERROR  out  1  sticky mismatch/response error flag; cleared on the next accepted start.
- ERR_COUNT  out  9  number of failed transactions in the current run; saturating.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR_W/3/1/1  write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel.
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR_W/3/1/1  read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel.

Behaviour:
- Reset values (asynchronous on ARESETN=0): all VALID/READY outputs 0, TXN_DONE 0, BUSY 0, ERROR 0, ERR_COUNT 0, index 0, FSM in IDLE. A reset mid-transaction drops every VALID immediately; no run resumes after reset.
- Fixed outputs: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- Start detection: a start is accepted only in IDLE or DONE, on INIT_TXN=1 when the previous-cycle INIT_TXN was 0. Starts in any other state are ignored.
- Accepting a start, in the same cycle: clear TXN_DONE, ERROR and ERR_COUNT; set index to 0; set BUSY.
- Transactions are strictly one at a time; there is no pipelining.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- WR_ADDR_DATA:
  - AWVALID and WVALID rise together in the first cycle.
  - Each VALID falls the cycle after its own handshake (VALID & READY).
  - AWADDR and WDATA stay stable while their VALID is high.
  - Move to WR_RESP once both handshakes have occurred; the two may occur in different cycles.
- WR_RESP:
  - BREADY=1.
  - On BVALID: if BRESP != 2'b00, set ERROR and increment ERR_COUNT.
  - If index = N-1: set index to 0 and go to RD_ADDR. Otherwise increment index and go to WR_ADDR_DATA.
- RD_ADDR: ARVALID=1 with ARADDR = C_BASE_ADDR + 4*index; on handshake go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID: compare RDATA with C_START_DATA + index. On mismatch or RRESP != 0, set ERROR and increment ERR_COUNT; at most one increment per transaction.
  - If the last index: go to DONE. Otherwise increment index and go to RD_ADDR.
- DONE: TXN_DONE=1, BUSY=0; stays in DONE until a new start.
- Latency with zero-wait slave: 3 cycles per write plus 2 cycles per read.
- ERR_COUNT saturates at 9'h1FF.

Optional Feature:
- Macro: AXI_SELFTEST_TIMEOUT_EN.
- When defined:
  - A counter runs in every non-IDLE/DONE state and resets on each handshake.
  - On reaching C_TIMEOUT_CYCLES: drop all VALID/READY, set ERROR, increment ERR_COUNT, go to DONE.
  - Adds output TIMEOUT (1 bit, sticky, cleared on start).
- When undefined: there is no counter and no TIMEOUT port, and the block waits indefinitely on a stalled slave.

Test Plan:
- Nominal run: zero-wait memory slave, default params, pulse INIT_TXN.
  - Required writes: 1,2,3,4 to 0x0, 0x4, 0x8, 0xC.
  - Required reads: the same 4 addresses.
  - End state: TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- Backpressure: AWREADY delayed 3 cycles, WREADY immediate.
  - WVALID drops after 1 cycle; AWVALID and AWADDR=0x0 are held stable 3 cycles.
  - No B phase starts before the AW handshake.
  - Run completes clean.
- Data error: slave returns 0xDEAD at read address 0x8.
  - ERROR=1, ERR_COUNT=1.
  - Remaining read of 0xC still issued; TXN_DONE=1.
- Response error: BRESP=2'b10 on write to 0x4 and RRESP=2'b10 on read of 0x4 → ERR_COUNT=2.
- Control edge cases:
  - INIT_TXN held high for 20 cycles yields exactly one run.
  - INIT_TXN pulsed mid-run is ignored.
  - ARESETN low during RD_DATA drops RREADY and BUSY immediately.
  - A second start after DONE clears ERROR and ERR_COUNT.
- With AXI_SELFTEST_TIMEOUT_EN and C_TIMEOUT_CYCLES=16: ARREADY tied 0 → after 16 cycles ARVALID=0, TIMEOUT=1, ERROR=1, TXN_DONE=1.
